// File: rtl/mdu_hilo.sv
// mdu_hilo: MIPS multiply/divide unit with HI/LO registers.
// Multi-cycle multiply and radix-2 restoring divide with pipeline stall and flush abort.
module mdu_hilo #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int MAXC = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_ma, r_mb;
    logic [WIDTH-1:0]   r_q, r_rem, r_dvs, r_hi, r_lo;
    logic               r_sq, r_sr, r_dz, r_busy, r_done;
    logic               w_accept, w_mul, w_div, w_sgn, w_sa, w_sb, w_ge;
    logic               w_mul_last, w_div_last;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rmd;
    logic [WIDTH:0]     w_sh, w_diff;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept   = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_mul      = (op_i == 3'd1) || (op_i == 3'd2);
    assign w_div      = (op_i == 3'd3) || (op_i == 3'd4);
    assign w_sgn      = (op_i == 3'd1) || (op_i == 3'd3);
    assign w_sa       = w_sgn && a_i[WIDTH-1];
    assign w_sb       = w_sgn && b_i[WIDTH-1];
    assign w_abs_a    = w_sa ? -a_i : a_i;
    assign w_abs_b    = w_sb ? -b_i : b_i;
    assign w_prod     = r_ma * r_mb;
    assign w_sh       = {r_rem, r_q[WIDTH-1]};
    assign w_diff     = w_sh - {1'b0, r_dvs};
    assign w_ge       = !w_diff[WIDTH];
    // Divide by zero leaves |a| as remainder, so only the quotient needs overriding.
    assign w_quo      = r_dz ? '1 : (r_sq ? -r_q : r_q);
    assign w_rmd      = r_sr ? -r_rem : r_rem;
    assign w_mul_last = r_cnt == CW'(MUL_LAT - 1);
    assign w_div_last = r_cnt == CW'(WIDTH);

    assign stall_o = (w_accept && (w_mul || w_div)) || (r_state == S_MUL) || (r_state == S_DIV);
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !w_accept ? S_IDLE : w_mul ? S_MUL : w_div ? S_DIV : S_IDLE;
            S_MUL:   w_next = flush_i ? S_IDLE : w_mul_last ? S_DONE : S_MUL;
            S_DIV:   w_next = flush_i ? S_IDLE : w_div_last ? S_DONE : S_DIV;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_MUL) || (w_next == S_DIV);
            r_done  <= w_next == S_DONE;
            r_cnt   <= ((r_state == S_MUL) || (r_state == S_DIV)) ? r_cnt + 1'b1 : '0;
            if (w_accept && op_i == 3'd5)
                r_hi <= a_i;
            if (w_accept && op_i == 3'd6)
                r_lo <= a_i;
            if (r_state == S_MUL && w_mul_last && !flush_i)
                {r_hi, r_lo} <= w_prod;
            if (r_state == S_DIV && w_div_last && !flush_i) begin
                r_hi <= w_rmd;
                r_lo <= w_quo;
            end
        end
    end

    // Operand/iteration datapath; contents are don't-care outside MUL/DIV.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ma  <= {{WIDTH{w_sa}}, a_i};
            r_mb  <= {{WIDTH{w_sb}}, b_i};
            r_q   <= w_abs_a;
            r_rem <= '0;
            r_dvs <= w_abs_b;
            r_sq  <= w_sa ^ w_sb;
            r_sr  <= w_sa;
            r_dz  <= b_i == '0;
        end else if (r_state == S_DIV && !w_div_last) begin
            r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed vector table plus hand-written flush/reset sequences for mdu_hilo.
module tb_mdu_hilo;
    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i, hi_o, lo_o;
    logic        stall_o, busy_o, done_o;
    int          n_cmp = 0;
    int          n_mis = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          ns, nb;
    } vec_t;

    vec_t vt[15];

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Holds start_i like a stalled EX instruction, including through the DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int ns, output int nb, output int nd);
        bit fin;
        fin = 0; ns = 0; nb = 0; nd = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        for (int k = 0; k < 100 && !fin; k++) begin
            #1;
            if (busy_o) nb++;
            if (done_o) nd++;
            if (!stall_o) fin = 1;
            else begin
                ns++;
                @(negedge clk);
            end
        end
        if (!fin) begin
            n_cmp++;
            n_mis++;
            $display("FAIL timeout: stall_o still high after 100 cycles, op %0d", op);
        end
        @(negedge clk);
        start_i = 1'b0; op_i = 3'd0;
        repeat (3) begin
            #1;
            if (busy_o) nb++;
            if (done_o) nd++;
            @(negedge clk);
        end
    endtask

    task automatic flush_div(input int cyc);
        int nd;
        nd = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd4; a_i = 32'd100; b_i = 32'd7;
        repeat (cyc) @(negedge clk);
        start_i = 1'b0; op_i = 3'd0; flush_i = 1'b1;
        #1 chk("flush_busy_before", busy_o, 1);
        @(negedge clk);
        flush_i = 1'b0;
        #1 chk("flush_busy_after", busy_o, 0);
        chk("flush_stall_after", stall_o, 0);
        repeat (40) begin
            if (done_o) nd++;
            @(negedge clk);
            #1;
        end
        chk("flush_no_done", nd, 0);
        chk("flush_hi", hi_o, 32'h11);
        chk("flush_lo", lo_o, 32'h22);
    endtask

    initial begin
        int ns, nb, nd;
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0;
        vt[0]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3, 2};
        vt[1]  = '{3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 3, 2};
        vt[2]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3, 2};
        vt[3]  = '{3'd2, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 3, 2};
        vt[4]  = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 34, 33};
        vt[5]  = '{3'd4, 32'd7,        32'd100,      32'h00000007, 32'h00000000, 34, 33};
        vt[6]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33};
        vt[7]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, 33};
        vt[8]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 33};
        vt[9]  = '{3'd3, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 34, 33};
        vt[10] = '{3'd3, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 34, 33};
        vt[11] = '{3'd5, 32'h12345678, 32'd9,        32'h12345678, 32'hFFFFFFFF, 0, 0};
        vt[12] = '{3'd6, 32'h9ABCDEF0, 32'd9,        32'h12345678, 32'h9ABCDEF0, 0, 0};
        vt[13] = '{3'd0, 32'd1,        32'd2,        32'h12345678, 32'h9ABCDEF0, 0, 0};
        vt[14] = '{3'd7, 32'd3,        32'd4,        32'h12345678, 32'h9ABCDEF0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_stall", stall_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, ns, nb, nd);
            chk($sformatf("v%0d_hi", i), hi_o, vt[i].hi);
            chk($sformatf("v%0d_lo", i), lo_o, vt[i].lo);
            chk($sformatf("v%0d_stall", i), ns, vt[i].ns);
            chk($sformatf("v%0d_busy", i), nb, vt[i].nb);
            chk($sformatf("v%0d_done", i), nd, (vt[i].ns > 0) ? 1 : 0);
        end

        // mthi then mtlo on back-to-back cycles
        start_i = 1'b1; op_i = 3'd5; a_i = 32'hAAAA0001;
        #1 chk("b2b_stall0", stall_o, 0);
        @(negedge clk);
        op_i = 3'd6; a_i = 32'hBBBB0002;
        #1 chk("b2b_hi", hi_o, 32'hAAAA0001);
        chk("b2b_stall1", stall_o, 0);
        @(negedge clk);
        start_i = 1'b0; op_i = 3'd0;
        #1 chk("b2b_lo", lo_o, 32'hBBBB0002);
        chk("b2b_done", done_o, 0);
        chk("b2b_busy", busy_o, 0);

        run_op(3'd5, 32'h11, 32'd0, ns, nb, nd);
        run_op(3'd6, 32'h22, 32'd0, ns, nb, nd);
        flush_div(10);
        flush_div(33);

        // flush during DONE keeps the completed multiply result
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd2; a_i = 32'd3; b_i = 32'd5;
        repeat (3) @(negedge clk);
        #1 chk("done_flush_pulse", done_o, 1);
        start_i = 1'b0; op_i = 3'd0; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1 chk("done_flush_hi", hi_o, 0);
        chk("done_flush_lo", lo_o, 32'd15);
        chk("done_flush_busy", busy_o, 0);

        // start_i held through DONE must not launch a second divide
        run_op(3'd4, 32'd100, 32'd7, ns, nb, nd);
        chk("held_lo", lo_o, 32'hE);
        chk("held_busy", nb, 33);
        chk("held_done", nd, 1);

        // reset in the middle of a divide
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd4; a_i = 32'd100; b_i = 32'd7;
        repeat (5) @(negedge clk);
        start_i = 1'b0; op_i = 3'd0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_hi", hi_o, 0);
        chk("midrst_lo", lo_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_stall", stall_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
